// File: rtl/jogador_automatico_pkg.sv
// Shared state codes, default timing and helpers for the automatic player.
// The game top level reuses ESTADO_W for its db_estado hex display.
package jogador_automatico_pkg;

  localparam int ESTADO_W            = 4;
  localparam int BOTOES_W            = 4;
  localparam int PROFUNDIDADE_PADRAO = 16;
  localparam int T_PRESS_PADRAO      = 20;
  localparam int T_GAP_PADRAO        = 80;

  typedef enum logic [ESTADO_W-1:0] {
    ST_IDLE      = 4'd0,
    ST_PRESSIONA = 4'd1,
    ST_SOLTA     = 4'd2,
    ST_FIM       = 4'd3
  } estado_e;

  // A valid press has exactly one button set.
  function automatic logic eh_one_hot(input logic [BOTOES_W-1:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Sequence-load and replay signals between a controller and the automatic player.
interface jogador_automatico_if;
  import jogador_automatico_pkg::*;

  logic                escreve;
  logic [3:0]          endereco_esc;
  logic [BOTOES_W-1:0] dado_esc;
  logic                iniciar;
  logic [3:0]          tamanho;
  logic [BOTOES_W-1:0] botoes;
  logic                ocupado;
  logic                pronto;
  logic                erro;
  logic [ESTADO_W-1:0] db_estado;

  modport master (
    output escreve, endereco_esc, dado_esc, iniciar, tamanho,
    input  botoes, ocupado, pronto, erro, db_estado
  );

  modport slave (
    input  escreve, endereco_esc, dado_esc, iniciar, tamanho,
    output botoes, ocupado, pronto, erro, db_estado
  );

endinterface

// File: rtl/jogador_automatico_contador_tempo.sv
// Up-counter with synchronous clear; saturates at valor_final and flags it.
module contador_tempo #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] valor_final,
  output logic         fim
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == valor_final) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + W'(1'b1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim = (cnt_q == valor_final);

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: replays stored button patterns with fixed press/gap timing.
// Outputs are registered from the current state, so they trail the state by one cycle.
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int T_PRESS      = T_PRESS_PADRAO,
  parameter int T_GAP        = T_GAP_PADRAO
) (
  input  logic                 clock,
  input  logic                 reset,
  jogador_automatico_if.slave  bus
);

  localparam int IDX_W = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam int T_MAX = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] FIM_PRESS = TW'(T_PRESS - 1);
  localparam logic [TW-1:0] FIM_GAP   = TW'(T_GAP - 1);

  estado_e             estado_q, estado_d;
  logic [3:0]          idx_q, idx_d;
  logic [3:0]          limite_q, limite_d;
  logic [BOTOES_W-1:0] mem_q [PROFUNDIDADE];
  logic [BOTOES_W-1:0] mem_d [PROFUNDIDADE];
  logic [BOTOES_W-1:0] botoes_q, botoes_d;
  logic                ocupado_q, ocupado_d;
  logic                pronto_q, pronto_d;
  logic                erro_q, erro_d;
  logic [ESTADO_W-1:0] db_estado_q, db_estado_d;

  logic [IDX_W-1:0]    end_leitura_s;
  logic [IDX_W-1:0]    end_escrita_s;
  logic [BOTOES_W-1:0] entrada_s;
  logic                tempo_fim_s;
  logic                tempo_clr_s;
  logic [TW-1:0]       tempo_final_s;

  // Addresses wrap modulo the depth so small memories still replay cleanly.
  assign end_leitura_s = IDX_W'({1'b0, idx_q} % 5'(PROFUNDIDADE));
  assign end_escrita_s = IDX_W'({1'b0, bus.endereco_esc} % 5'(PROFUNDIDADE));
  assign entrada_s     = mem_q[end_leitura_s];

  assign tempo_final_s = (estado_q == ST_SOLTA) ? FIM_GAP : FIM_PRESS;
  assign tempo_clr_s   = (estado_d != estado_q) || (estado_q == ST_IDLE);

  contador_tempo #(.W(TW)) u_tempo (
    .clock       (clock),
    .reset       (reset),
    .clr         (tempo_clr_s),
    .valor_final (tempo_final_s),
    .fim         (tempo_fim_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= ST_IDLE;
      idx_q       <= 4'd0;
      limite_q    <= 4'd0;
      botoes_q    <= 4'd0;
      ocupado_q   <= 1'b0;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
      db_estado_q <= 4'd0;
    end else begin
      estado_q    <= estado_d;
      idx_q       <= idx_d;
      limite_q    <= limite_d;
      botoes_q    <= botoes_d;
      ocupado_q   <= ocupado_d;
      pronto_q    <= pronto_d;
      erro_q      <= erro_d;
      db_estado_q <= db_estado_d;
    end
  end

  // Sequence memory deliberately survives reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    mem_d = mem_q;
    if ((estado_q == ST_IDLE) && bus.escreve) begin
      mem_d[end_escrita_s] = bus.dado_esc;
    end else begin
      mem_d = mem_q;
    end
  end

  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    limite_d = limite_q;
    case (estado_q)
      ST_IDLE: begin
        if (bus.iniciar) begin
          estado_d = ST_PRESSIONA;
          idx_d    = 4'd0;
          limite_d = bus.tamanho;
        end else begin
          estado_d = ST_IDLE;
        end
      end
      ST_PRESSIONA: begin
        if (tempo_fim_s) begin
          estado_d = ST_SOLTA;
        end else begin
          estado_d = ST_PRESSIONA;
        end
      end
      ST_SOLTA: begin
        if (!tempo_fim_s) begin
          estado_d = ST_SOLTA;
        end else if (idx_q == limite_q) begin
          estado_d = ST_FIM;
        end else begin
          estado_d = ST_PRESSIONA;
          idx_d    = idx_q + 4'd1;
        end
      end
      ST_FIM:  estado_d = ST_IDLE;
      default: estado_d = ST_IDLE;
    endcase
  end

  // A non-one-hot entry still occupies its slot, but drives nothing and flags erro.
  always_comb begin
    botoes_d    = 4'd0;
    ocupado_d   = 1'b0;
    pronto_d    = 1'b0;
    erro_d      = erro_q;
    db_estado_d = estado_q;
    case (estado_q)
      ST_IDLE: begin
        if (bus.iniciar) begin
          erro_d = 1'b0;
        end else begin
          erro_d = erro_q;
        end
      end
      ST_PRESSIONA: begin
        ocupado_d = 1'b1;
        if (eh_one_hot(entrada_s)) begin
          botoes_d = entrada_s;
        end else begin
          botoes_d = 4'd0;
          erro_d   = 1'b1;
        end
      end
      ST_SOLTA: ocupado_d = 1'b1;
      ST_FIM: begin
        ocupado_d = 1'b1;
        pronto_d  = 1'b1;
      end
      default: db_estado_d = 4'd0;
    endcase
  end

  assign bus.botoes    = botoes_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.pronto    = pronto_q;
  assign bus.erro      = erro_q;
  assign bus.db_estado = db_estado_q;

endmodule

// File: doc/jogador_automatico.md
# jogador_automatico

Synthesizable automatic player for the memory game: replays a stored sequence of button presses into the game's `botoes` input with fixed press/release timing. It drives the same button interface the game core receives from the physical keys. Use it for board-level self-test and for regression of demonstration-mode rounds without a human operator. It sits beside the game core; its `botoes` output is OR-ed or muxed with the physical keys at the top level.

## Interface
Parameters:
- `PROFUNDIDADE`, 16: number of sequence entries stored.
- `T_PRESS`, 20: cycles each button is held high (≥1).
- `T_GAP`, 80: cycles buttons stay low after each press (≥1).

Ports:
- `clock`  in  1  system clock (1 kHz on board).
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `escreve`  in  1  write strobe for sequence memory.
- `endereco_esc`  in  4  write address.
- `dado_esc`  in  4  button pattern to store.
- `iniciar`  in  1  start replay (level sampled in IDLE).
- `tamanho`  in  4  index of last entry to play; plays `tamanho+1` entries.
- `botoes`  out  4  button pattern to the game core.
- `ocupado`  out  1  high from the first cycle after start through FIM.
- `pronto`  out  1  one-cycle pulse at end of replay.
- `erro`  out  1  sticky; a replayed entry was not one-hot.
- `db_estado`  out  4  current FSM state code.

## Operation
- Memory: `PROFUNDIDADE`×4 array with asynchronous read. It is not cleared by `reset`, so contents survive reset.
- Writes are accepted only in IDLE: if `escreve`=1 in IDLE, `mem[endereco_esc] <= dado_esc`. Writes in any other state are ignored.
- State IDLE (code 0): `botoes`=0, `ocupado`=0.
  - If `iniciar`=1: latch `tamanho` into `limite`, set `idx`=0, clear `erro`, go to PRESSIONA.
- State PRESSIONA (code 1): `botoes` = `mem[idx]` if one-hot, else 0 with `erro` set.
  - After `T_PRESS` cycles, go to SOLTA.
- State SOLTA (code 2): `botoes`=0.
  - After `T_GAP` cycles: if `idx`==`limite`, go to FIM; else `idx++` and go to PRESSIONA.
- State FIM (code 3): `pronto`=1 for exactly one cycle, then IDLE.
- `iniciar` outside IDLE is ignored. `tamanho` changes after start are ignored.
- A non-one-hot entry, including 0000, still consumes its full press+gap slot. The timing of later presses is unchanged.
- `erro` holds until the next accepted `iniciar` or `reset`.
- Simultaneous `escreve` and `iniciar` in IDLE: the write commits at that edge and is visible to the first PRESSIONA read.
- `tamanho` ≥ `PROFUNDIDADE` is impossible with 4-bit width and depth 16. For smaller depths, `idx` wraps modulo `PROFUNDIDADE`.

## Timing
- All outputs are registered. Reset values: `botoes`=0000, `ocupado`=0, `pronto`=0, `erro`=0, `db_estado`=0 (IDLE).
- `reset` mid-operation: at the next edge, go to IDLE with all outputs at reset values. Memory is untouched.
- `iniciar` sampled high at edge k ⇒ `botoes` carries entry 0 from edge k+1.
- Each entry: exactly `T_PRESS` cycles high, then exactly `T_GAP` cycles low. Period is `T_PRESS+T_GAP`.
- `pronto` rises at edge k+1+(L+1)(`T_PRESS`+`T_GAP`), where L = latched `tamanho`.
- `ocupado` falls one cycle after `pronto`; a new `iniciar` is accepted on that cycle.
- The timer resets on every state entry. Its width is ceil(log2(max(`T_PRESS`,`T_GAP`)+1)).

## Structure
- Shared header/package: state codes (IDLE=0, PRESSIONA=1, SOLTA=2, FIM=3) and default timing constants. The game top level reuses the 4-bit state-code width for `db_estado` hex display.
- One sub-module, `contador_tempo`: a parameterized up-counter with synchronous clear and terminal-count flag. It is instantiated once and cleared on each state entry; the FSM selects the terminal value (`T_PRESS`/`T_GAP`).
- FSM, `idx` register and memory live in `jogador_automatico` itself.

## Test plan
- Reset, then idle 10 cycles ⇒ `botoes`=0000, `ocupado`=0, `pronto`=0, `db_estado`=0.
- Load 0001, 0010, 0100, 1000; `tamanho`=3; pulse `iniciar` ⇒
  - patterns appear in order, each 20 cycles high and 80 low;
  - `pronto` pulses exactly 401 cycles after the start edge;
  - `erro`=0.
- Store 0011 at entry 1, `tamanho`=2 ⇒ slot 1 drives 0000 for its full slot, `erro`=1 until the next `iniciar`, and total duration is still 3×100 cycles.
- Assert `escreve` and re-pulse `iniciar` during replay ⇒ memory unchanged (verified by a later replay) and the current replay is unaffected.
- Assert `reset` in the middle of the second PRESSIONA ⇒ next cycle `botoes`=0 and IDLE. A following `iniciar` replays from entry 0 using the preserved contents.
- Drive `escreve`+`iniciar` in the same IDLE cycle to address 0 with 1000 ⇒ first press is 1000.
